sqrt_iter_unit: RTL and testbench

- Parametrised sequential integer square-root unit: computes `root_o = floor(sqrt(valor_i))` for a WIDTH-bit unsigned operand.
- Uses the restoring digit-by-digit (radix-2) method, one result bit per cycle, so latency is fixed at WIDTH/2 cycles regardless of operand value.
- Contains its own controller and a start/ready/done handshake, so it drops into a datapath as a self-contained functional unit.
- An optional remainder output is compiled in with a macro.

---
 rtl/sqrt_iter_unit_if.sv | 31 +++
 rtl/sqrt_iter_unit.sv | 110 +++++++++++
 tb/tb_sqrt_iter_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_iter_unit_if.sv
// rtl/sqrt_iter_unit_if.sv - start/ready/done handshake bundle for sqrt_iter_unit (rem_o present with SQRT_REMAINDER_EN)
interface sqrt_iter_unit_if #(
    parameter int WIDTH = 16
);
    localparam int RW = WIDTH / 2;

    logic [WIDTH-1:0] valor_i;
    logic             start_i;
    logic             ready_o;
    logic             done_o;
    logic [RW-1:0]    root_o;
`ifdef SQRT_REMAINDER_EN
    logic [RW:0]      rem_o;
`endif

    modport master (
        output valor_i, start_i,
        input  ready_o, done_o, root_o
`ifdef SQRT_REMAINDER_EN
        , input rem_o
`endif
    );

    modport slave (
        input  valor_i, start_i,
        output ready_o, done_o, root_o
`ifdef SQRT_REMAINDER_EN
        , output rem_o
`endif
    );
endinterface

// File: rtl/sqrt_iter_unit.sv
// rtl/sqrt_iter_unit.sv - sequential restoring radix-2 integer square root, one root bit per cycle
// Optional remainder output: define SQRT_REMAINDER_EN.
module sqrt_iter_unit #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sqrt_iter_unit_if.slave bus
);
    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           iterate;

    logic [WIDTH-1:0] op;
    logic [RW+1:0]    rem;
    logic [RW-1:0]    root;
    logic [CW-1:0]    cnt;

    logic [RW+3:0]    rem_sh;
    logic [RW+3:0]    sub_val;
    logic [RW+1:0]    trial;
    logic             trial_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iterate   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start_i) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // trial_neg is the borrow of the full-width trial subtraction; a
    // non-negative trial always fits the rem register, so only its low bits are kept.
    assign rem_sh    = {rem, op[WIDTH-1:WIDTH-2]};
    assign sub_val   = {2'b00, root, 2'b01};
    assign trial_neg = (rem_sh < sub_val);
    assign trial     = rem_sh[RW+1:0] - sub_val[RW+1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op   <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (accept) begin
            op   <= bus.valor_i;
            rem  <= '0;
            root <= '0;
            cnt  <= CW'(RW - 1);
        end else if (iterate) begin
            if (!trial_neg) begin
                rem  <= trial;
                root <= {root[RW-2:0], 1'b1};
            end else begin
                rem  <= rem_sh[RW+1:0];
                root <= {root[RW-2:0], 1'b0};
            end
            op <= {op[WIDTH-3:0], 2'b00};
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.ready_o = (state != CALC);
    assign bus.done_o  = (state == DONE);
    assign bus.root_o  = root;
`ifdef SQRT_REMAINDER_EN
    assign bus.rem_o   = rem[RW:0];
`endif
endmodule

// File: tb/tb_sqrt_iter_unit.sv
// tb/tb_sqrt_iter_unit.sv - directed self-checking bench for sqrt_iter_unit at WIDTH=16 and WIDTH=8
module tb_sqrt_iter_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sqrt_iter_unit_if #(.WIDTH(16)) b16 ();
    sqrt_iter_unit_if #(.WIDTH(8))  b8 ();

    sqrt_iter_unit #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    sqrt_iter_unit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run16(input logic [15:0] v, input logic [7:0] er, input logic [8:0] erem, input string nm);
        int k;
        int busy_bad;
        busy_bad = 0;
        @(negedge clk);
        b16.valor_i = v;
        b16.start_i = 1'b1;
        @(posedge clk);
        #1;
        b16.start_i = 1'b0;
        b16.valor_i = ~v;
        for (k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (b16.done_o) break;
            if (b16.ready_o !== 1'b0) busy_bad++;
        end
        total++;
        if (k !== 8) begin
            bad++;
            $display("FAIL %s latency got=%0d want=8", nm, k);
        end
        total++;
        if (busy_bad !== 0) begin
            bad++;
            $display("FAIL %s ready_in_calc got=%0d high cycles want=0", nm, busy_bad);
        end
        total++;
        if (b16.root_o !== er) begin
            bad++;
            $display("FAIL %s root got=%0d want=%0d", nm, b16.root_o, er);
        end
`ifdef SQRT_REMAINDER_EN
        total++;
        if (b16.rem_o !== erem) begin
            bad++;
            $display("FAIL %s rem got=%0d want=%0d", nm, b16.rem_o, erem);
        end
`endif
        @(posedge clk);
        #1;
        total++;
        if (b16.done_o !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse got=%b want=0", nm, b16.done_o);
        end
        total++;
        if (b16.root_o !== er) begin
            bad++;
            $display("FAIL %s root_hold got=%0d want=%0d", nm, b16.root_o, er);
        end
    endtask

    task automatic run8(input logic [7:0] v, input logic [3:0] er, input logic [4:0] erem, input string nm);
        int k;
        @(negedge clk);
        b8.valor_i = v;
        b8.start_i = 1'b1;
        @(posedge clk);
        #1;
        b8.start_i = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (b8.done_o) break;
        end
        total++;
        if (k !== 4) begin
            bad++;
            $display("FAIL %s latency got=%0d want=4", nm, k);
        end
        total++;
        if (b8.root_o !== er) begin
            bad++;
            $display("FAIL %s root got=%0d want=%0d", nm, b8.root_o, er);
        end
`ifdef SQRT_REMAINDER_EN
        total++;
        if (b8.rem_o !== erem) begin
            bad++;
            $display("FAIL %s rem got=%0d want=%0d", nm, b8.rem_o, erem);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        b16.valor_i = '0;
        b16.start_i = 1'b0;
        b8.valor_i  = '0;
        b8.start_i  = 1'b0;
        #12;
        total++;
        if (b16.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", b16.ready_o);
        end
        total++;
        if (b16.done_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", b16.done_o);
        end
        total++;
        if (b16.root_o !== 8'd0) begin
            bad++;
            $display("FAIL reset_root got=%0d want=0", b16.root_o);
        end
`ifdef SQRT_REMAINDER_EN
        total++;
        if (b16.rem_o !== 9'd0) begin
            bad++;
            $display("FAIL reset_rem got=%0d want=0", b16.rem_o);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_extremes();
        run16(16'd0, 8'd0, 9'd0, "zero");
        run16(16'd65535, 8'd255, 9'd510, "max");
    endtask

    task automatic test_square_neighbour();
        run16(16'd144, 8'd12, 9'd0, "sq144");
        run16(16'd143, 8'd11, 9'd22, "sq143");
    endtask

    task automatic test_busy();
        int k;
        @(negedge clk);
        b16.valor_i = 16'd143;
        b16.start_i = 1'b1;
        @(posedge clk);
        #1;
        b16.start_i = 1'b0;
        for (k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                b16.valor_i = 16'd9;
                b16.start_i = 1'b1;
            end else if (k == 3) begin
                b16.start_i = 1'b0;
            end
            if (b16.done_o) break;
        end
        total++;
        if (k !== 8) begin
            bad++;
            $display("FAIL busy latency got=%0d want=8", k);
        end
        total++;
        if (b16.root_o !== 8'd11) begin
            bad++;
            $display("FAIL busy root got=%0d want=11", b16.root_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int k;
        int k2;
        @(negedge clk);
        b16.valor_i = 16'd143;
        b16.start_i = 1'b1;
        @(posedge clk);
        #1;
        b16.valor_i = 16'd9;
        for (k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (b16.done_o) break;
        end
        total++;
        if (k !== 8 || b16.root_o !== 8'd11) begin
            bad++;
            $display("FAIL b2b_first got=%0d@%0d want=11@8", b16.root_o, k);
        end
        for (k2 = 1; k2 <= 14; k2++) begin
            @(posedge clk);
            #1;
            if (b16.done_o) break;
        end
        b16.start_i = 1'b0;
        total++;
        if (k2 !== 9) begin
            bad++;
            $display("FAIL b2b_period got=%0d want=9", k2);
        end
        total++;
        if (b16.root_o !== 8'd3) begin
            bad++;
            $display("FAIL b2b_root got=%0d want=3", b16.root_o);
        end
`ifdef SQRT_REMAINDER_EN
        total++;
        if (b16.rem_o !== 9'd0) begin
            bad++;
            $display("FAIL b2b_rem got=%0d want=0", b16.rem_o);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        b16.valor_i = 16'd65535;
        b16.start_i = 1'b1;
        @(posedge clk);
        #1;
        b16.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (b16.ready_o !== 1'b1 || b16.done_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ctrl got=ready%b done%b want=ready1 done0", b16.ready_o, b16.done_o);
        end
        total++;
        if (b16.root_o !== 8'd0) begin
            bad++;
            $display("FAIL midrst_root got=%0d want=0", b16.root_o);
        end
`ifdef SQRT_REMAINDER_EN
        total++;
        if (b16.rem_o !== 9'd0) begin
            bad++;
            $display("FAIL midrst_rem got=%0d want=0", b16.rem_o);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (b16.done_o) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL midrst_nodone got=%0d want=0", dones);
        end
        run16(16'd144, 8'd12, 9'd0, "after_rst");
    endtask

    task automatic test_width8();
        run8(8'd200, 4'd14, 5'd4, "w8_200");
        run8(8'd255, 4'd15, 5'd30, "w8_255");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_extremes();
        test_square_neighbour();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
